spi_game_cmd_rx: RTL and testbench

//  SPI slave in the Avalon_CLK_50 domain. Receives 2-byte command frames (address, data) from the PIC32 master.

---
 rtl/qbert_spi_pkg.sv | 13 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_game_cmd_rx.sv | 173 +++++++++++++++++
 tb/tb_spi_game_cmd_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qbert_spi_pkg.sv
// Shared types and constants for the PIC32 -> Qbert game command SPI receiver.
package qbert_spi_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, ERR} spi_state_t;

  localparam logic [7:0]  DEF_ADDR_STATUS = 8'h01;
  localparam logic [7:0]  DEF_ADDR_JUMP   = 8'h02;
  localparam logic [7:0]  DEF_ADDR_ACC    = 8'h03;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned BYTE_BITS  = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with one extra delay flop
// providing single-cycle rise/fall pulses on the synchronized level.
// Every flop resets to 0, so a line already low at reset release shows no fall.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain plus the edge-detect delay flop
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_game_cmd_rx.sv
// SPI slave receiving 2-byte (address, data) frames and holding the three game
// registers for the MTL/Qbert controller. Optional MISO reply path is enabled by
// defining SPI_MISO_EN.
module spi_game_cmd_rx
  import qbert_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  ADDR_STATUS = DEF_ADDR_STATUS,
  parameter logic [7:0]  ADDR_JUMP   = DEF_ADDR_JUMP,
  parameter logic [7:0]  ADDR_ACC    = DEF_ADDR_ACC,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             Avalon_CLK_50,
  input  logic             Avalon_reset,
  input  logic             SPI_SCK,
  input  logic             SPI_CS_n,
  input  logic             SPI_MOSI,
  output logic [7:0]       oSPI_game_status,
  output logic [7:0]       oSPI_jump,
  output logic [7:0]       oSPI_acc,
  output logic             oJump_pulse,
  output logic [ERR_W-1:0] oFrame_err
`ifdef SPI_MISO_EN
  ,
  input  logic [7:0]       iMISO_byte,
  output logic             oSPI_MISO
`endif
);

  localparam logic [4:0] CntFrame = 5'(FRAME_BITS);
  localparam logic [4:0] CntByte  = 5'(BYTE_BITS);

  logic sck_rise, sck_fall, unused_sck_lvl;
  logic cs_n_lvl, cs_n_rise, cs_n_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_state_t state_q;
  logic [15:0] shift_q, shift_nxt;
  logic [4:0]  cnt_q, cnt_nxt;
  logic [7:0]  addr_q;
  logic        commit_q;
  logic [ERR_W-1:0] err_inc;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk_i   (Avalon_CLK_50),
    .rst_i   (Avalon_reset),
    .async_i (SPI_SCK),
    .level_o (unused_sck_lvl),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i   (Avalon_CLK_50),
    .rst_i   (Avalon_reset),
    .async_i (SPI_CS_n),
    .level_o (cs_n_lvl),
    .rise_o  (cs_n_rise),
    .fall_o  (cs_n_fall)
  );

  // MOSI needs only its level; same depth keeps it aligned with the SCK rise pulse
  always_ff @(posedge Avalon_CLK_50) begin
    if (Avalon_reset) mosi_sync_q <= '0;
    else              mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Shift a bit in first; CS_n rise in the same cycle is judged on the result
  always_comb begin
    shift_nxt = shift_q;
    cnt_nxt   = cnt_q;
    if (sck_rise) begin
      shift_nxt = {shift_q[14:0], mosi_s};
      cnt_nxt   = cnt_q + 5'd1;
    end
    err_inc = (&oFrame_err) ? oFrame_err : oFrame_err + ERR_W'(1);
  end

  // Frame FSM; register writes land one cycle after the commit decision
  always_ff @(posedge Avalon_CLK_50) begin
    if (Avalon_reset) begin
      state_q          <= IDLE;
      shift_q          <= '0;
      cnt_q            <= '0;
      addr_q           <= '0;
      commit_q         <= 1'b0;
      oSPI_game_status <= '0;
      oSPI_jump        <= '0;
      oSPI_acc         <= '0;
      oJump_pulse      <= 1'b0;
      oFrame_err       <= '0;
    end else begin
      commit_q    <= 1'b0;
      oJump_pulse <= 1'b0;
      if (commit_q) begin
        if (addr_q == ADDR_STATUS) begin
          oSPI_game_status <= shift_q[7:0];
        end else if (addr_q == ADDR_JUMP) begin
          oSPI_jump   <= shift_q[7:0];
          oJump_pulse <= 1'b1;
        end else if (addr_q == ADDR_ACC) begin
          oSPI_acc <= shift_q[7:0];
        end
      end
      unique case (state_q)
        IDLE: begin
          if (cs_n_fall) begin
            state_q <= ADDR;
            shift_q <= '0;
            cnt_q   <= '0;
          end
        end
        ADDR, DATA: begin
          shift_q <= shift_nxt;
          cnt_q   <= cnt_nxt;
          if (cs_n_rise) begin
            if (cnt_nxt == '0) begin
              state_q <= IDLE;
            end else if (cnt_nxt == CntFrame) begin
              state_q  <= IDLE;
              commit_q <= 1'b1;
            end else begin
              state_q    <= ERR;
              oFrame_err <= err_inc;
            end
          end else if (state_q == ADDR && cnt_nxt == CntByte) begin
            state_q <= DATA;
            addr_q  <= shift_nxt[7:0];
          end else if (cnt_nxt == CntFrame) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (sck_rise) begin
            state_q    <= ERR;
            oFrame_err <= err_inc;
          end else if (cs_n_rise) begin
            state_q  <= IDLE;
            commit_q <= 1'b1;
          end
        end
        ERR: begin
          if (cs_n_lvl) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPI_MISO_EN
  logic [7:0] miso_sr_q;

  // Reply byte loads as the address completes; the first data-phase SCK fall
  // belongs to the last address bit, so shifting starts from bit 9 onward
  always_ff @(posedge Avalon_CLK_50) begin
    if (Avalon_reset) begin
      miso_sr_q <= '0;
    end else if (state_q == ADDR && !cs_n_rise && cnt_nxt == CntByte) begin
      miso_sr_q <= iMISO_byte;
    end else if (state_q == DATA && sck_fall && cnt_q > CntByte) begin
      miso_sr_q <= {miso_sr_q[6:0], 1'b0};
    end
  end

  assign oSPI_MISO = (state_q == DATA) & miso_sr_q[7];
`else
  logic unused_sck_fall;
  assign unused_sck_fall = sck_fall;
`endif

endmodule

// File: tb/tb_spi_game_cmd_rx.sv
// Bench for spi_game_cmd_rx: table of directed frames, hand-written timing,
// saturation and reset sequences, then random frames against a frame-level model.
module tb_spi_game_cmd_rx;

  logic       Avalon_CLK_50 = 1'b0;
  logic       Avalon_reset;
  logic       SPI_SCK, SPI_CS_n, SPI_MOSI;
  logic [7:0] oSPI_game_status, oSPI_jump, oSPI_acc;
  logic       oJump_pulse;
  logic [7:0] oFrame_err;
`ifdef SPI_MISO_EN
  logic [7:0]  iMISO_byte;
  logic        oSPI_MISO;
  logic [15:0] miso_rx;
`endif

  always #10 Avalon_CLK_50 = ~Avalon_CLK_50;

  spi_game_cmd_rx dut (
    .Avalon_CLK_50    (Avalon_CLK_50),
    .Avalon_reset     (Avalon_reset),
    .SPI_SCK          (SPI_SCK),
    .SPI_CS_n         (SPI_CS_n),
    .SPI_MOSI         (SPI_MOSI),
    .oSPI_game_status (oSPI_game_status),
    .oSPI_jump        (oSPI_jump),
    .oSPI_acc         (oSPI_acc),
    .oJump_pulse      (oJump_pulse),
    .oFrame_err       (oFrame_err)
`ifdef SPI_MISO_EN
    ,
    .iMISO_byte       (iMISO_byte),
    .oSPI_MISO        (oSPI_MISO)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;
  int pulse_cnt = 0;

  always @(negedge Avalon_CLK_50) if (oJump_pulse === 1'b1) pulse_cnt++;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         nbits;
    logic [7:0] st;
    logic [7:0] jp;
    logic [7:0] ac;
    logic [7:0] er;
    int         pulses;
  } vec_t;

  vec_t vecs[10];

  // Frame-level reference state
  logic [7:0] m_st, m_jp, m_ac, m_er;
  int         m_pulses;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b);
    SPI_MOSI = b;
    repeat (4) @(negedge Avalon_CLK_50);
`ifdef SPI_MISO_EN
    miso_rx = {miso_rx[14:0], oSPI_MISO};
`endif
    SPI_SCK = 1'b1;
    repeat (4) @(negedge Avalon_CLK_50);
    SPI_SCK = 1'b0;
  endtask

  task automatic frame_body(input logic [7:0] a, input logic [7:0] d, input int nbits);
    logic [15:0] f;
    f = {a, d};
    SPI_CS_n = 1'b0;
    repeat (4) @(negedge Avalon_CLK_50);
    for (int i = 0; i < nbits; i++) begin
      send_bit(f[15]);
      f = {f[14:0], 1'($urandom)};
    end
    repeat (4) @(negedge Avalon_CLK_50);
  endtask

  task automatic frame_end();
    SPI_CS_n = 1'b1;
    repeat (8) @(negedge Avalon_CLK_50);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input int nbits);
    pulse_cnt = 0;
    frame_body(a, d, nbits);
    frame_end();
  endtask

  // Only a complete 16-bit frame commits; any other nonzero length is an error
  task automatic model_frame(input logic [7:0] a, input logic [7:0] d, input int nbits);
    m_pulses = 0;
    if (nbits == 16) begin
      case (a)
        8'h01: m_st = d;
        8'h02: begin m_jp = d; m_pulses = 1; end
        8'h03: m_ac = d;
        default: ;
      endcase
    end else if (nbits != 0 && m_er != 8'hFF) begin
      m_er = m_er + 8'd1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_status"}, 32'(oSPI_game_status), 32'(m_st));
    check({tag, "_jump"}, 32'(oSPI_jump), 32'(m_jp));
    check({tag, "_acc"}, 32'(oSPI_acc), 32'(m_ac));
    check({tag, "_err"}, 32'(oFrame_err), 32'(m_er));
    check({tag, "_pulses"}, 32'(pulse_cnt), 32'(m_pulses));
  endtask

  initial begin
    vecs[0] = '{8'h02, 8'h03, 16, 8'hA5, 8'h03, 8'h00, 8'h00, 1};
    vecs[1] = '{8'h02, 8'h03, 16, 8'hA5, 8'h03, 8'h00, 8'h00, 1};
    vecs[2] = '{8'h01, 8'h3C, 11, 8'hA5, 8'h03, 8'h00, 8'h01, 0};
    vecs[3] = '{8'h02, 8'h77, 17, 8'hA5, 8'h03, 8'h00, 8'h02, 0};
    vecs[4] = '{8'h07, 8'hFF, 16, 8'hA5, 8'h03, 8'h00, 8'h02, 0};
    vecs[5] = '{8'h03, 8'h81, 0,  8'hA5, 8'h03, 8'h00, 8'h02, 0};
    vecs[6] = '{8'h03, 8'h81, 16, 8'hA5, 8'h03, 8'h81, 8'h02, 0};
    vecs[7] = '{8'h01, 8'h00, 8,  8'hA5, 8'h03, 8'h81, 8'h03, 0};
    vecs[8] = '{8'h01, 8'h5A, 16, 8'h5A, 8'h03, 8'h81, 8'h03, 0};
    vecs[9] = '{8'h02, 8'hC7, 16, 8'h5A, 8'hC7, 8'h81, 8'h03, 1};

    SPI_SCK = 1'b0;
    SPI_CS_n = 1'b1;
    SPI_MOSI = 1'b0;
    Avalon_reset = 1'b1;
`ifdef SPI_MISO_EN
    iMISO_byte = 8'h00;
    miso_rx = '0;
`endif
    repeat (5) @(negedge Avalon_CLK_50);
    Avalon_reset = 1'b0;
    repeat (5) @(negedge Avalon_CLK_50);

    check("reset_status", 32'(oSPI_game_status), 32'h00);
    check("reset_jump", 32'(oSPI_jump), 32'h00);
    check("reset_acc", 32'(oSPI_acc), 32'h00);
    check("reset_pulse", 32'(oJump_pulse), 32'h0);
    check("reset_err", 32'(oFrame_err), 32'h00);

    // CS_n pin rise to register update is SYNC_STAGES+2 = 4 clocks
    pulse_cnt = 0;
    frame_body(8'h01, 8'hA5, 16);
    SPI_CS_n = 1'b1;
    repeat (3) @(negedge Avalon_CLK_50);
    check("lat_status_before", 32'(oSPI_game_status), 32'h00);
    @(negedge Avalon_CLK_50);
    check("lat_status_at4", 32'(oSPI_game_status), 32'hA5);
    repeat (6) @(negedge Avalon_CLK_50);
    check("lat_jump_untouched", 32'(oSPI_jump), 32'h00);
    check("lat_acc_untouched", 32'(oSPI_acc), 32'h00);
    check("lat_no_pulse", 32'(pulse_cnt), 32'd0);

    // Jump pulse lands on the update cycle and lasts exactly one clock
    pulse_cnt = 0;
    frame_body(8'h02, 8'h03, 16);
    SPI_CS_n = 1'b1;
    repeat (3) @(negedge Avalon_CLK_50);
    check("jpulse_before", 32'(oJump_pulse), 32'h0);
    @(negedge Avalon_CLK_50);
    check("jpulse_at4", 32'(oJump_pulse), 32'h1);
    @(negedge Avalon_CLK_50);
    check("jpulse_after", 32'(oJump_pulse), 32'h0);
    repeat (5) @(negedge Avalon_CLK_50);

    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].a, vecs[i].d, vecs[i].nbits);
      check($sformatf("vec%0d_status", i), 32'(oSPI_game_status), 32'(vecs[i].st));
      check($sformatf("vec%0d_jump", i), 32'(oSPI_jump), 32'(vecs[i].jp));
      check($sformatf("vec%0d_acc", i), 32'(oSPI_acc), 32'(vecs[i].ac));
      check($sformatf("vec%0d_err", i), 32'(oFrame_err), 32'(vecs[i].er));
      check($sformatf("vec%0d_pulses", i), 32'(pulse_cnt), 32'(vecs[i].pulses));
    end

    // Error counter saturation: drive it to FF, then one more error
    m_st = 8'h5A; m_jp = 8'hC7; m_ac = 8'h81; m_er = 8'h03;
    while (m_er != 8'hFF) begin
      send_frame(8'h01, 8'h00, 1);
      model_frame(8'h01, 8'h00, 1);
    end
    check("sat_reach_ff", 32'(oFrame_err), 32'hFF);
    send_frame(8'h03, 8'h00, 5);
    check("sat_hold_ff", 32'(oFrame_err), 32'hFF);
    check("sat_acc_kept", 32'(oSPI_acc), 32'h81);

    // Reset during bit 9 of frame 03,40, released with CS_n still low
    SPI_CS_n = 1'b0;
    repeat (4) @(negedge Avalon_CLK_50);
    for (int i = 0; i < 8; i++) send_bit(i >= 6);  // 8'h03
    SPI_MOSI = 1'b0;
    repeat (4) @(negedge Avalon_CLK_50);
    SPI_SCK = 1'b1;
    Avalon_reset = 1'b1;
    repeat (4) @(negedge Avalon_CLK_50);
    SPI_SCK = 1'b0;
    Avalon_reset = 1'b0;
    for (int i = 1; i < 8; i++) send_bit(i == 1);  // rest of 8'h40
    repeat (4) @(negedge Avalon_CLK_50);
    pulse_cnt = 0;
    frame_end();
    m_st = 8'h00; m_jp = 8'h00; m_ac = 8'h00; m_er = 8'h00; m_pulses = 0;
    check_model("rstmid");
    send_frame(8'h03, 8'h40, 16);
    model_frame(8'h03, 8'h40, 16);
    check_model("rstmid_clean");

`ifdef SPI_MISO_EN
    iMISO_byte = 8'hC3;
    send_frame(8'h01, 8'h00, 16);
    model_frame(8'h01, 8'h00, 16);
    check("miso_rx", 32'(miso_rx), 32'h00C3);
    check("miso_idle_low", 32'(oSPI_MISO), 32'h0);
    check_model("miso_frame");
`endif

    // Random frames against the frame-level model
    for (int n = 0; n < 40; n++) begin
      logic [7:0] a, d;
      int nb, sel;
      sel = int'($urandom_range(0, 4));
      a = (sel == 4) ? 8'($urandom_range(4, 255)) : 8'(sel);
      d = 8'($urandom);
      nb = ($urandom_range(0, 9) < 6) ? 16 : int'($urandom_range(0, 20));
      send_frame(a, d, nb);
      model_frame(a, d, nb);
      check_model($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
